dl_sequencer: RTL and testbench

DL_SEQUENCER -- requirements
Module: dl_sequencer

---
 rtl/dl_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_dl_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dl_sequencer
//  Purpose  : ROM download sequencer. Forwards host ROM bytes to the core ROM
//             port through a single-byte pending buffer, generates the core
//             reset sequence, and captures game-mod and DIP configuration bytes.
//  Options  : DL_CHECKSUM_EN - when defined, rom_sum accumulates the bytes
//             written to the ROM port. Otherwise rom_sum is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module dl_sequencer #(
    parameter int RESET_HOLD = 16,
    parameter int ROM_SIZE   = 65536
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic        soft_reset,
    input  logic        dn_busy,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        core_reset,
    output logic        rom_valid,
    output logic [7:0]  mod,
    output logic [23:0] dip,
    output logic        wr_err,
    output logic [15:0] rom_sum
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RUN   = 3'd4
    } state_t;

    localparam int                HOLD_W      = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0] C_HOLD_INIT = HOLD_W'(RESET_HOLD - 1);
    localparam logic [24:0]       C_ROM_LIMIT = 25'(ROM_SIZE);
    localparam logic [16:0]       C_CNT_MAX   = 17'h1FFFF;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [16:0]       cnt_q, cnt_d;
    logic              buf_full_q, buf_full_d;
    logic [15:0]       buf_addr_q;
    logic [7:0]        buf_data_q;
    logic              rom_valid_q, rom_valid_d;
    logic              core_reset_q;
    logic              wr_err_q;
    logic [7:0]        mod_q;
    logic [23:0]       dip_q;

    logic w_rom_start;
    logic w_rom_wr;
    logic w_accept;
    logic w_overrun;
    logic w_dn_wr;
    logic w_load_entry;
    logic w_mod_wr;
    logic w_dip_wr;

    assign w_rom_start = ioctl_download && (ioctl_index == 8'd0);
    assign w_rom_wr    = ioctl_wr && (ioctl_index == 8'd0) && (state_q == ST_LOAD);
    // Only an empty buffer accepts; out-of-range bytes vanish silently.
    assign w_accept    = w_rom_wr && (ioctl_addr < C_ROM_LIMIT) && !buf_full_q;
    assign w_overrun   = w_rom_wr && buf_full_q;
    // The ROM port write fires as soon as the core can take it, giving the
    // single-cycle minimum latency from the host strobe.
    assign w_dn_wr     = buf_full_q && !dn_busy;
    assign w_mod_wr    = ioctl_wr && (ioctl_index == 8'd1) && (ioctl_addr == 25'd0);
    assign w_dip_wr    = ioctl_wr && (ioctl_index == 8'd254) &&
                         (ioctl_addr[24:2] == 23'd0) && (ioctl_addr[1:0] != 2'b11);

    // Next-state logic for the sequencer, pending buffer and byte counter.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        rom_valid_d  = rom_valid_q;
        w_load_entry = 1'b0;
        buf_full_d   = buf_full_q;
        if (w_accept) begin
            buf_full_d = 1'b1;
        end else if (w_dn_wr) begin
            buf_full_d = 1'b0;
        end
        cnt_d = cnt_q;
        if (w_dn_wr && (cnt_q != C_CNT_MAX)) begin
            cnt_d = cnt_q + 17'd1;
        end
        case (state_q)
            ST_IDLE: begin
                if (w_rom_start) begin
                    state_d      = ST_LOAD;
                    w_load_entry = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_rom_start) begin
                    state_d      = ST_LOAD;
                    w_load_entry = 1'b1;
                end else if (soft_reset) begin
                    state_d = ST_HOLD;
                    hold_d  = C_HOLD_INIT;
                end
            end
            ST_LOAD: begin
                if (!ioctl_download) begin
                    rom_valid_d = (cnt_d != 17'd0);
                    if (buf_full_d) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_HOLD;
                        hold_d  = C_HOLD_INIT;
                    end
                end
            end
            ST_DRAIN: begin
                if (!buf_full_d) begin
                    rom_valid_d = (cnt_d != 17'd0);
                    state_d     = ST_HOLD;
                    hold_d      = C_HOLD_INIT;
                end
            end
            ST_HOLD: begin
                // A held soft reset keeps restarting the hold period.
                if (soft_reset) begin
                    hold_d = C_HOLD_INIT;
                end else if (hold_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (w_load_entry) begin
            cnt_d       = 17'd0;
            rom_valid_d = 1'b0;
        end
    end

    // Sequencer state, pending byte buffer and registered status outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            cnt_q        <= 17'd0;
            buf_full_q   <= 1'b0;
            buf_addr_q   <= 16'd0;
            buf_data_q   <= 8'd0;
            rom_valid_q  <= 1'b0;
            core_reset_q <= 1'b1;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            cnt_q        <= cnt_d;
            buf_full_q   <= buf_full_d;
            rom_valid_q  <= rom_valid_d;
            core_reset_q <= (state_d != ST_RUN);
            if (w_accept) begin
                buf_addr_q <= ioctl_addr[15:0];
                buf_data_q <= ioctl_dout;
            end
            if (w_overrun) begin
                wr_err_q <= 1'b1;
            end
        end
    end

    // Game-variant and DIP configuration bytes, accepted in any state.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mod_q <= 8'd0;
            dip_q <= 24'd0;
        end else begin
            if (w_mod_wr) begin
                mod_q <= ioctl_dout;
            end
            if (w_dip_wr) begin
                case (ioctl_addr[1:0])
                    2'd0:    dip_q[7:0]   <= ioctl_dout;
                    2'd1:    dip_q[15:8]  <= ioctl_dout;
                    default: dip_q[23:16] <= ioctl_dout;
                endcase
            end
        end
    end

`ifdef DL_CHECKSUM_EN
    logic [15:0] sum_q;

    // Running sum of bytes written to the ROM port, restarted per download.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= 16'd0;
        end else if (w_load_entry) begin
            sum_q <= 16'd0;
        end else if (w_dn_wr) begin
            sum_q <= sum_q + {8'd0, buf_data_q};
        end
    end

    assign rom_sum = sum_q;
`else
    assign rom_sum = 16'd0;
`endif

    assign ioctl_wait = buf_full_q;
    assign dn_wr      = w_dn_wr;
    assign dn_addr    = buf_addr_q;
    assign dn_data    = buf_data_q;
    assign core_reset = core_reset_q;
    assign rom_valid  = rom_valid_q;
    assign wr_err     = wr_err_q;
    assign mod        = mod_q;
    assign dip        = dip_q;

endmodule
`default_nettype wire

// File: tb/tb_dl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dl_sequencer
//  Purpose  : Directed self-checking bench for dl_sequencer: ROM download path,
//             backpressure, download end during a stall, config bytes, soft
//             reset hold time, address bounds and asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dl_sequencer;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        soft_reset;
    logic        dn_busy;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        core_reset;
    logic        rom_valid;
    logic [7:0]  mod;
    logic [23:0] dip;
    logic        wr_err;
    logic [15:0] rom_sum;

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          dn_count  = 0;
    logic [15:0] last_addr = 16'd0;
    logic [7:0]  last_data = 8'd0;

`ifdef DL_CHECKSUM_EN
    localparam logic [15:0] C_EXP_SUM = 16'h0066;
`else
    localparam logic [15:0] C_EXP_SUM = 16'h0000;
`endif

    dl_sequencer dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .soft_reset     (soft_reset),
        .dn_busy        (dn_busy),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .core_reset     (core_reset),
        .rom_valid      (rom_valid),
        .mod            (mod),
        .dip            (dip),
        .wr_err         (wr_err),
        .rom_sum        (rom_sum)
    );

    always #5 clk_sys = ~clk_sys;

    // Record every ROM port write seen on an active edge.
    always @(posedge clk_sys) begin
        if (dn_wr) begin
            dn_count  <= dn_count + 1;
            last_addr <= dn_addr;
            last_data <= dn_data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // One ROM byte with the port free: dn_wr must appear one cycle later.
    task automatic rom_write(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        check_eq("rom_dn_wr", 32'(dn_wr), 32'd1);
        check_eq("rom_dn_addr", 32'(dn_addr), 32'(a[15:0]));
        check_eq("rom_dn_data", 32'(dn_data), 32'(d));
        ioctl_wr = 1'b0;
        tick();
    endtask

    // Config byte written via a short transfer of the given index.
    task automatic cfg_write(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        ioctl_download = 1'b1;
        ioctl_index    = idx;
        ioctl_addr     = a;
        ioctl_dout     = d;
        ioctl_wr       = 1'b1;
        tick();
        check_eq("cfg_no_wait", 32'(ioctl_wait), 32'd0);
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        tick();
    endtask

    initial begin
        int   base;
        int   wait_hi;
        logic seen;
        logic cr_low;

        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'd0;
        soft_reset     = 1'b0;
        dn_busy        = 1'b0;
        ticks(3);
        check_eq("rst_core_reset", 32'(core_reset), 32'd1);
        check_eq("rst_wait", 32'(ioctl_wait), 32'd0);
        check_eq("rst_dn_wr", 32'(dn_wr), 32'd0);
        check_eq("rst_rom_valid", 32'(rom_valid), 32'd0);
        check_eq("rst_wr_err", 32'(wr_err), 32'd0);
        check_eq("rst_cfg", {mod, dip}, 32'd0);
        check_eq("rst_sum", 32'(rom_sum), 32'd0);
        reset_n = 1'b1;
        ticks(2);
        check_eq("idle_core_reset", 32'(core_reset), 32'd1);

        // Basic download of three bytes
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        tick();
        rom_write(25'd0, 8'h11);
        rom_write(25'd1, 8'h22);
        rom_write(25'd2, 8'h33);
        check_eq("load_dn_count", 32'(dn_count), 32'd3);
        check_eq("load_core_reset", 32'(core_reset), 32'd1);
        ioctl_download = 1'b0;
        ticks(16);
        check_eq("hold_last_cycle", 32'(core_reset), 32'd1);
        check_eq("rom_valid_set", 32'(rom_valid), 32'd1);
        tick();
        check_eq("run_core_reset", 32'(core_reset), 32'd0);
        check_eq("rom_sum", 32'(rom_sum), 32'(C_EXP_SUM));

        // Configuration bytes
        cfg_write(8'd1, 25'd0, 8'h02);
        check_eq("mod_set", 32'(mod), 32'h02);
        cfg_write(8'd1, 25'd5, 8'h09);
        check_eq("mod_bad_addr", 32'(mod), 32'h02);
        cfg_write(8'd254, 25'd1, 8'hA5);
        check_eq("dip_sw1", 32'(dip), 32'h00A500);
        cfg_write(8'd254, 25'd8, 8'h77);
        check_eq("dip_addr8_ignored", 32'(dip), 32'h00A500);
        cfg_write(8'd254, 25'd2, 8'h3C);
        check_eq("dip_sw2", 32'(dip), 32'h3CA500);
        cfg_write(8'd7, 25'd0, 8'h44);
        ticks(2);
        check_eq("other_index_run", 32'(core_reset), 32'd0);

        // Soft reset pulse
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        ticks(15);
        check_eq("soft_hold_last", 32'(core_reset), 32'd1);
        tick();
        check_eq("soft_release", 32'(core_reset), 32'd0);

        // New download clears status
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        tick();
        check_eq("reload_valid_clr", 32'(rom_valid), 32'd0);
        check_eq("reload_sum_clr", 32'(rom_sum), 32'd0);
        check_eq("reload_core_reset", 32'(core_reset), 32'd1);

        // Out-of-range ROM address
        base       = dn_count;
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h10000;
        ioctl_dout = 8'h55;
        tick();
        check_eq("oob_no_wait", 32'(ioctl_wait), 32'd0);
        check_eq("oob_no_dn_wr", 32'(dn_wr), 32'd0);
        ioctl_wr = 1'b0;
        ticks(2);
        check_eq("oob_dn_count", 32'(dn_count - base), 32'd0);

        // Backpressure with an overrun write during the stall
        check_eq("pre_wr_err", 32'(wr_err), 32'd0);
        base       = dn_count;
        wait_hi    = 0;
        seen       = 1'b0;
        dn_busy    = 1'b1;
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'd5;
        ioctl_dout = 8'h5A;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (ioctl_wait) wait_hi++;
            if (dn_wr) seen = 1'b1;
            case (k)
                1: ioctl_wr = 1'b0;
                2: begin
                    ioctl_wr   = 1'b1;
                    ioctl_addr = 25'd6;
                    ioctl_dout = 8'h66;
                end
                3: ioctl_wr = 1'b0;
                5: dn_busy = 1'b0;
                default: ;
            endcase
        end
        check_eq("stall_no_dn_wr", 32'(seen), 32'd0);
        check_eq("stall_wait_cycles", 32'(wait_hi), 32'd5);
        tick();
        check_eq("stall_wait_drop", 32'(ioctl_wait), 32'd0);
        ticks(2);
        check_eq("stall_single_dn_wr", 32'(dn_count - base), 32'd1);
        check_eq("stall_dn_data", 32'(last_data), 32'h5A);
        check_eq("stall_dn_addr", 32'(last_addr), 32'h0005);
        check_eq("overrun_wr_err", 32'(wr_err), 32'd1);

        // Download ends while the byte is stalled
        base       = dn_count;
        dn_busy    = 1'b1;
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'd7;
        ioctl_dout = 8'h07;
        tick();
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        ticks(4);
        check_eq("drain_wait", 32'(ioctl_wait), 32'd1);
        check_eq("drain_core_reset", 32'(core_reset), 32'd1);
        check_eq("drain_no_dn_wr", 32'(dn_count - base), 32'd0);
        dn_busy = 1'b0;
        cr_low  = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (!core_reset) cr_low = 1'b1;
        end
        check_eq("drain_hold_core_reset", 32'(cr_low), 32'd0);
        tick();
        check_eq("drain_run", 32'(core_reset), 32'd0);
        check_eq("drain_dn_count", 32'(dn_count - base), 32'd1);
        check_eq("drain_dn_data", 32'(last_data), 32'h07);
        check_eq("drain_rom_valid", 32'(rom_valid), 32'd1);

        // Asynchronous reset with a byte pending
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        tick();
        base       = dn_count;
        dn_busy    = 1'b1;
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'd0;
        ioctl_dout = 8'h99;
        tick();
        ioctl_wr = 1'b0;
        tick();
        check_eq("pending_wait", 32'(ioctl_wait), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_wait", 32'(ioctl_wait), 32'd0);
        check_eq("arst_core_reset", 32'(core_reset), 32'd1);
        check_eq("arst_flags", {29'd0, dn_wr, rom_valid, wr_err}, 32'd0);
        check_eq("arst_cfg", {mod, dip}, 32'd0);
        check_eq("arst_sum", 32'(rom_sum), 32'd0);
        tick();
        dn_busy        = 1'b0;
        ioctl_download = 1'b0;
        reset_n        = 1'b1;
        ticks(3);
        check_eq("arst_byte_dropped", 32'(dn_count - base), 32'd0);
        check_eq("arst_idle_core_reset", 32'(core_reset), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
